e_mdu_param: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the execute stage; sits beside the single-cycle ALU.
- Owns the HI/LO register pair and models multiply and divide latency with a down-counter.
- Exposes `busy` so the hazard unit can stall any instruction that touches HI/LO while an operation is in flight.
- Supports signed and unsigned multiply/divide, MTHI and MTLO, plus optional multiply-accumulate.

---
 rtl/e_mdu_param.sv | 162 ++++++++++++++++
 tb/tb_e_mdu_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_param.sv
// e_mdu_param: multi-cycle multiply/divide unit owning HI/LO, with latency modelled by a down-counter.
// Define MDU_MADD_EN to enable multiply-accumulate ops 7-10 (MADD/MADDU/MSUB/MSUBU).
module e_mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, sh_q, sh_d, sl_q, sl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, dz_q, dz_d;

  logic             accept_s, is_mul_s, is_div_s, is_sgn_s, is_mthi_s, is_mtlo_s;
  logic [W2-1:0]    a_ext_s, b_ext_s, prod_s, mul_res_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, q_mag_s, r_mag_s, quo_s, rem_s;
`ifdef MDU_MADD_EN
  logic             is_acc_s, is_sub_s;
`endif

  // Opcode decode
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    is_sgn_s  = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
`ifdef MDU_MADD_EN
    is_acc_s  = 1'b0;
    is_sub_s  = 1'b0;
`endif
    case (op)
      4'd1:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; end
      4'd2:  is_mul_s = 1'b1;
      4'd3:  begin is_div_s = 1'b1; is_sgn_s = 1'b1; end
      4'd4:  is_div_s = 1'b1;
      4'd5:  is_mthi_s = 1'b1;
      4'd6:  is_mtlo_s = 1'b1;
`ifdef MDU_MADD_EN
      4'd7:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; is_acc_s = 1'b1; end
      4'd8:  begin is_mul_s = 1'b1; is_acc_s = 1'b1; end
      4'd9:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
      4'd10: begin is_mul_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept_s = start & ~kill & ~busy_q;

  // Arithmetic: signed divide done on magnitudes so MIN / -1 wraps back to MIN with remainder 0
  always_comb begin
    a_ext_s = is_sgn_s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext_s = is_sgn_s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod_s  = a_ext_s * b_ext_s;
`ifdef MDU_MADD_EN
    if (is_acc_s) begin
      mul_res_s = is_sub_s ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end else begin
      mul_res_s = prod_s;
    end
`else
    mul_res_s = prod_s;
`endif
    a_mag_s = (is_sgn_s && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_mag_s = (is_sgn_s && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    q_mag_s = (b == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (a_mag_s / b_mag_s);
    r_mag_s = (b == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (a_mag_s % b_mag_s);
    quo_s   = (is_sgn_s && (a[WIDTH-1] ^ b[WIDTH-1])) ? (~q_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : q_mag_s;
    rem_s   = (is_sgn_s && a[WIDTH-1]) ? (~r_mag_s + {{(WIDTH-1){1'b0}}, 1'b1}) : r_mag_s;
  end

  // Next state: accept a new op when idle, otherwise count down and commit the shadow at zero
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    sh_d   = sh_q;
    sl_d   = sl_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dz_d   = dz_q;
    if (busy_q) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
        hi_d   = sh_q;
        lo_d   = sl_q;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (accept_s) begin
      if (is_mthi_s) begin
        hi_d = a;
        dz_d = 1'b0;
      end else if (is_mtlo_s) begin
        lo_d = a;
        dz_d = 1'b0;
      end else if (is_mul_s) begin
        {sh_d, sl_d} = mul_res_s;
        cnt_d        = CW'(MUL_CYCLES);
        busy_d       = 1'b1;
        dz_d         = 1'b0;
      end else if (is_div_s) begin
        cnt_d  = CW'(DIV_CYCLES);
        busy_d = 1'b1;
        if (b == {WIDTH{1'b0}}) begin
          sl_d = {WIDTH{1'b1}};
          sh_d = a;
          dz_d = 1'b1;
        end else begin
          sl_d = quo_s;
          sh_d = rem_s;
          dz_d = 1'b0;
        end
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      sh_q   <= {WIDTH{1'b0}};
      sl_q   <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      sh_q   <= sh_d;
      sl_q   <= sl_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dz_q   <= dz_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;
endmodule

// File: tb/tb_e_mdu_param.sv
// Scoreboard bench for e_mdu_param: the driver predicts HI/LO/dz and commit cycle with plain
// integer arithmetic; a negedge monitor compares them, plus busy and HI/LO hold while in flight.
module tb_e_mdu_param;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, kill = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, dz;
  logic [31:0] hi, lo;

  e_mdu_param #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .kill(kill),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          due;
    int          acc;
    bit          win;
    logic [31:0] hi, lo, ohi, olo;
    logic        dz;
  } item_t;
  item_t sbq[$];

  int checks = 0, failures = 0;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
  logic        dz_m = 1'b0;

  // Monitor: compare at the expected commit edge, hold during busy, stable when idle
  logic [31:0] last_hi = 32'd0, last_lo = 32'd0;
  logic        last_dz = 1'b0;
  bit          started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      if (edge_n >= sbq[0].due) begin
        item_t e;
        e = sbq.pop_front();
        chk("commit_edge", 64'(edge_n), 64'(e.due));
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("dz", {63'd0, dz}, {63'd0, e.dz});
        chk("busy_after", {63'd0, busy}, 64'd0);
        last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
        started = 1'b1;
      end else if (sbq[0].win && edge_n >= sbq[0].acc) begin
        chk("busy_inflight", {63'd0, busy}, 64'd1);
        chk("hi_hold", {32'd0, hi}, {32'd0, sbq[0].ohi});
        chk("lo_hold", {32'd0, lo}, {32'd0, sbq[0].olo});
      end
    end else if (started) begin
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_hilo", {hi, lo}, {last_hi, last_lo});
      chk("idle_dz", {63'd0, dz}, {63'd0, last_dz});
    end
  end

  task automatic push_reset();
    item_t e;
    e.due = edge_n + 1; e.acc = edge_n + 1; e.win = 1'b0;
    e.hi = 32'd0; e.lo = 32'd0; e.ohi = 32'd0; e.olo = 32'd0; e.dz = 1'b0;
    sbq.push_back(e);
    hi_m = 32'd0; lo_m = 32'd0; dz_m = 1'b0;
  endtask

  // Driver: predict the result, issue the op, then wait out its latency
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke, input int rst_at);
    item_t       e;
    logic [63:0] r, p;
    int          lat, sq, sr;
    bit          mt;
    lat = 0; mt = 1'b0; r = {hi_m, lo_m}; p = 64'd0;
    e.ohi = hi_m; e.olo = lo_m;
    case (o)
      4'd1: begin r = longint'($signed(x)) * longint'($signed(y)); lat = MULC; end
      4'd2: begin r = {32'd0, x} * {32'd0, y}; lat = MULC; end
      4'd3, 4'd4: begin
        lat = DIVC;
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (o == 4'd3 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else if (o == 4'd3) begin
          sq = $signed(x) / $signed(y); sr = $signed(x) % $signed(y);
          r[31:0] = sq; r[63:32] = sr;
        end else r = {x % y, x / y};
      end
      4'd5: begin r[63:32] = x; mt = 1'b1; end
      4'd6: begin r[31:0] = x; mt = 1'b1; end
`ifdef MDU_MADD_EN
      4'd7, 4'd9:  p = longint'($signed(x)) * longint'($signed(y));
      4'd8, 4'd10: p = {32'd0, x} * {32'd0, y};
`endif
      default: ;
    endcase
`ifdef MDU_MADD_EN
    if (o == 4'd7 || o == 4'd8)  begin r = r + p; lat = MULC; end
    if (o == 4'd9 || o == 4'd10) begin r = r - p; lat = MULC; end
`endif
    start = 1'b1; op = o; a = x; b = y;
    if (lat != 0 || mt) begin
      {hi_m, lo_m} = r;
      dz_m = (o == 4'd3 || o == 4'd4) && (y == 32'd0);
      e.acc = edge_n + 1; e.due = edge_n + 1 + lat; e.win = (lat != 0);
      e.hi = hi_m; e.lo = lo_m; e.dz = dz_m;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= lat; i++) begin
      if (i == rst_at) begin
        start = 1'b0; reset = 1'b1;
        sbq.delete();
        push_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (poke != 0 && (i == 2 || i == 4)) begin
        start = 1'b1; op = 4'd2; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] ro;
    repeat (2) @(posedge clk);
    #1;
    push_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    issue(4'd1, 32'hFFFF_FFFD, 32'h0000_0004, 0, 0);
    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
    issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    issue(4'd4, 32'h1234_5678, 32'h0000_0000, 0, 0);
    issue(4'd6, 32'h0000_0005, 32'h0000_0000, 0, 0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    issue(4'd1, 32'h0000_1234, 32'hFFFF_0001, 1, 0);

    start = 1'b1; kill = 1'b1; op = 4'd1; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    issue(4'd3, 32'h0000_0064, 32'h0000_0007, 0, 3);
    repeat (2) @(posedge clk);
    #1;

`ifdef MDU_MADD_EN
    issue(4'd5, 32'h0000_0000, 32'd0, 0, 0);
    issue(4'd6, 32'h0000_0010, 32'd0, 0, 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
    issue(4'd10, 32'h0000_0001, 32'h0000_000F, 0, 0);
`else
    issue(4'd5, 32'h0000_00AA, 32'd0, 0, 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
    repeat (3) @(posedge clk);
    #1;
`endif

    for (int n = 0; n < 60; n++) begin
`ifdef MDU_MADD_EN
      ro = 4'($urandom_range(1, 10));
`else
      ro = 4'($urandom_range(1, 6));
`endif
      issue(ro, rnd(), rnd(), 0, 0);
    end

    for (int w = 0; w < 50 && sbq.size() > 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected commits never seen", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
